// File: rtl/reg_uniform_mode_pkg.sv
// Shared types for the per-register access-mode register file.
// Optional build macro in the top: REG_UNIFORM_MODE_RO_ERR_EN.
package reg_uniform_mode_pkg;

   typedef enum logic [1:0] {REG_RW, REG_RO, REG_W1C, REG_W1S} reg_mode_e;

   typedef enum logic {IDLE, RESP} state_e;

endpackage

// File: rtl/reg_uniform_mode_if.sv
// Flattened register-bus request/response bundle between the bus demux and the register file.
interface reg_uniform_mode_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   reg_addr;
   logic                    reg_write;
   logic [DATA_WIDTH-1:0]   reg_wdata;
   logic [DATA_WIDTH/8-1:0] reg_wstrb;
   logic                    reg_valid;
   logic                    reg_ready;
   logic [DATA_WIDTH-1:0]   reg_rdata;
   logic                    reg_error;

   modport master (
      output reg_addr, reg_write, reg_wdata, reg_wstrb, reg_valid,
      input  reg_ready, reg_rdata, reg_error
   );

   modport slave (
      input  reg_addr, reg_write, reg_wdata, reg_wstrb, reg_valid,
      output reg_ready, reg_rdata, reg_error
   );
endinterface

// File: rtl/reg_uniform_mode_cell.sv
// One register of the file: mode-dependent next-state logic on byte enables, set and clear
// vectors, plus the storage flop.
module reg_uniform_mode_cell
   import reg_uniform_mode_pkg::*;
#(
   parameter int        REG_WIDTH = 32,
   parameter reg_mode_e MODE      = REG_RW
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [REG_WIDTH-1:0]   init_val_i,
   input  logic [REG_WIDTH/8-1:0] sw_be_i,
   input  logic [REG_WIDTH-1:0]   sw_wdata_i,
   input  logic                   hw_we_i,
   input  logic [REG_WIDTH-1:0]   hw_wdata_i,
   input  logic [REG_WIDTH-1:0]   hw_set_i,
   output logic [REG_WIDTH-1:0]   q_o,
   output logic                   sw_wr_o
);

   logic [REG_WIDTH-1:0] q_q, q_d;
   logic [REG_WIDTH-1:0] mask;
   logic [REG_WIDTH-1:0] base;

   always_comb begin
      for (int b = 0; b < REG_WIDTH/8; b++) begin
         mask[b*8 +: 8] = {8{sw_be_i[b]}};
      end
   end

   assign base = hw_we_i ? hw_wdata_i : q_q;

   // W1C: hw_set is OR-ed last so a same-cycle set beats a software clear.
   always_comb begin
      q_d = q_q;
      case (MODE)
         REG_RW:  q_d = (sw_wdata_i & mask) | (base & ~mask);
         REG_RO:  q_d = base;
         REG_W1C: q_d = (q_q & ~(sw_wdata_i & mask)) | hw_set_i;
         REG_W1S: q_d = base | (sw_wdata_i & mask);
         default: q_d = q_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) q_q <= init_val_i;
      else       q_q <= q_d;
   end

   assign q_o     = q_q;
   assign sw_wr_o = (MODE != REG_RO) && (|sw_be_i);

endmodule

// File: rtl/reg_uniform_mode.sv
// Register file with per-register RW/RO/W1C/W1S modes and a registered 2-cycle response.
// Macro REG_UNIFORM_MODE_RO_ERR_EN: a write touching an RO register errors and is dropped.
module reg_uniform_mode
   import reg_uniform_mode_pkg::*;
#(
   parameter int        ADDR_WIDTH         = 32,
   parameter int        DATA_WIDTH         = 32,
   parameter int        NUM_REG            = 8,
   parameter int        REG_WIDTH          = 32,
   parameter reg_mode_e REG_MODE [NUM_REG] = '{default: REG_RW}
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_REG*REG_WIDTH-1:0] init_val_i,
   input  logic [NUM_REG-1:0]           hw_we_i,
   input  logic [NUM_REG*REG_WIDTH-1:0] hw_wdata_i,
   input  logic [NUM_REG*REG_WIDTH-1:0] hw_set_i,
   output logic [NUM_REG*REG_WIDTH-1:0] reg_q_o,
   output logic [NUM_REG-1:0]           wr_evt_o,
   reg_uniform_mode_if.slave            bus
);

   localparam int K         = DATA_WIDTH / REG_WIDTH;
   localparam int BPR       = REG_WIDTH / 8;
   localparam int NUM_WORDS = (NUM_REG + K - 1) / K;
   localparam int OFFS_W    = $clog2(DATA_WIDTH / 8);

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    error_q, error_d;
   logic [NUM_REG-1:0]      wr_evt_q, wr_evt_d;
   logic [NUM_REG-1:0]      sw_wr;
   logic [DATA_WIDTH-1:0]   word_val;
   logic [ADDR_WIDTH-1:0]   word_addr;
   logic                    commit;
   logic                    in_range;
   logic                    drop;

   assign word_addr = bus.reg_addr >> OFFS_W;
   assign in_range  = word_addr < ADDR_WIDTH'(NUM_WORDS);
   assign commit    = (state_q == IDLE) && bus.reg_valid;

`ifdef REG_UNIFORM_MODE_RO_ERR_EN
   logic [NUM_REG-1:0] ro_hit;
   assign drop = |ro_hit;
`else
   assign drop = 1'b0;
`endif

   for (genvar i = 0; i < NUM_REG; i++) begin : g_reg
      localparam int SLOT = i % K;
      localparam int WORD = i / K;

      logic           hit;
      logic [BPR-1:0] raw_be;
      logic [BPR-1:0] be;

      assign hit    = commit && bus.reg_write && (word_addr == ADDR_WIDTH'(WORD));
      assign raw_be = hit ? bus.reg_wstrb[SLOT*BPR +: BPR] : '0;
      assign be     = drop ? '0 : raw_be;
`ifdef REG_UNIFORM_MODE_RO_ERR_EN
      assign ro_hit[i] = (REG_MODE[i] == REG_RO) && (|raw_be);
`endif

      reg_uniform_mode_cell #(
         .REG_WIDTH (REG_WIDTH),
         .MODE      (REG_MODE[i])
      ) u_cell (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .init_val_i (init_val_i[i*REG_WIDTH +: REG_WIDTH]),
         .sw_be_i    (be),
         .sw_wdata_i (bus.reg_wdata[SLOT*REG_WIDTH +: REG_WIDTH]),
         .hw_we_i    (hw_we_i[i]),
         .hw_wdata_i (hw_wdata_i[i*REG_WIDTH +: REG_WIDTH]),
         .hw_set_i   (hw_set_i[i*REG_WIDTH +: REG_WIDTH]),
         .q_o        (reg_q_o[i*REG_WIDTH +: REG_WIDTH]),
         .sw_wr_o    (sw_wr[i])
      );
   end

   // Pre-write bus word; unused slots and out-of-range words read as zero.
   always_comb begin
      word_val = '0;
      for (int i = 0; i < NUM_REG; i++) begin
         if (word_addr == ADDR_WIDTH'(i / K)) begin
            word_val[(i % K)*REG_WIDTH +: REG_WIDTH] = reg_q_o[i*REG_WIDTH +: REG_WIDTH];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.reg_valid) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.reg_ready = (state_q == RESP);
   end

   always_comb begin
      rdata_d  = rdata_q;
      error_d  = error_q;
      wr_evt_d = '0;
      if (commit) begin
         rdata_d  = word_val;
         error_d  = !in_range || drop;
         wr_evt_d = sw_wr;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q  <= '0;
         error_q  <= 1'b0;
         wr_evt_q <= '0;
      end else begin
         rdata_q  <= rdata_d;
         error_q  <= error_d;
         wr_evt_q <= wr_evt_d;
      end
   end

   assign bus.reg_rdata = rdata_q;
   assign bus.reg_error = error_q;
   assign wr_evt_o      = wr_evt_q;

endmodule

// File: tb/tb_reg_uniform_mode.sv
// Scoreboard bench for reg_uniform_mode: stimulus queues expected responses, a monitor checks them.
module tb_reg_uniform_mode;
   import reg_uniform_mode_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NR = 8;
   localparam int RW = 32;
   localparam reg_mode_e MODES [NR] = '{REG_RW, REG_RW, REG_RW, REG_W1C,
                                        REG_RO, REG_W1S, REG_RW, REG_RW};
`ifdef REG_UNIFORM_MODE_RO_ERR_EN
   localparam logic RO_ERR = 1'b1;
`else
   localparam logic RO_ERR = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NR*RW-1:0]  init_val, hw_wdata, hw_set, reg_q;
   logic [NR-1:0]     hw_we, wr_evt;

   reg_uniform_mode_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   reg_uniform_mode #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_REG    (NR),
      .REG_WIDTH  (RW),
      .REG_MODE   (MODES)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .init_val_i (init_val),
      .hw_we_i    (hw_we),
      .hw_wdata_i (hw_wdata),
      .hw_set_i   (hw_set),
      .reg_q_o    (reg_q),
      .wr_evt_o   (wr_evt),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
   } resp_t;

   resp_t         exp_q [$];
   int            errors = 0;
   int            checks = 0;
   logic [RW-1:0] init_arr [NR];
   logic [RW-1:0] exp_reg  [NR];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NR; i++) begin
         chk($sformatf("%s_reg%0d", tag, i), reg_q[i*RW +: RW], exp_reg[i]);
      end
   endtask

   always @(negedge clk) begin
      resp_t e;
      if (bus.reg_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: ready=1 with no pending access");
         end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", bus.reg_rdata, e.rdata);
            chk("resp_error", bus.reg_error, e.err);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the response cycle.
   task automatic access(input string name, input logic [AW-1:0] addr, input logic wr,
                         input logic [DW-1:0] wdata, input logic [3:0] strb, input logic [RW-1:0] set3,
                         input logic [DW-1:0] exp_rdata, input logic exp_err, input logic [NR-1:0] exp_evt);
      resp_t e;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      exp_q.push_back(e);
      bus.reg_addr  = addr;
      bus.reg_write = wr;
      bus.reg_wdata = wdata;
      bus.reg_wstrb = strb;
      bus.reg_valid = 1'b1;
      hw_set[3*RW +: RW] = set3;
      chk({name, "_idle_ready"}, bus.reg_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      hw_set[3*RW +: RW] = '0;
      chk({name, "_ready"}, bus.reg_ready, 1'b1);
      chk({name, "_evt"}, wr_evt, exp_evt);
      @(posedge clk);
      @(negedge clk);
      bus.reg_valid = 1'b0;
      chk({name, "_evt_clr"}, wr_evt, '0);
      chk({name, "_ready_clr"}, bus.reg_ready, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      init_arr = '{32'h0, 32'h1111_2222, 32'hA5A5_0000, 32'h0, 32'h55, 32'h0, 32'h0, 32'h0};
      for (int i = 0; i < NR; i++) init_val[i*RW +: RW] = init_arr[i];
      exp_reg       = init_arr;
      rst           = 1'b1;
      hw_we         = '0;
      hw_wdata      = '0;
      hw_set        = '0;
      bus.reg_addr  = '0;
      bus.reg_write = 1'b0;
      bus.reg_wdata = '0;
      bus.reg_wstrb = '0;
      bus.reg_valid = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_reg2", reg_q[2*RW +: RW], 32'hA5A5_0000);
      chk("reset_ready", bus.reg_ready, 1'b0);
      chk("reset_error", bus.reg_error, 1'b0);
      chk("reset_evt", wr_evt, '0);
      check_regs("reset");

      access("rw_wr", 32'h4, 1'b1, 32'hDEAD_BEEF, 4'b0011, '0, 32'h1111_2222, 1'b0, 8'h02);
      exp_reg[1] = 32'h1111_BEEF;
      check_regs("rw_wr");

      access("rw_rd", 32'h4, 1'b0, 32'h0, 4'b0000, '0, 32'h1111_BEEF, 1'b0, 8'h00);

      hw_set[3*RW +: RW] = 32'hF;
      @(negedge clk);
      hw_set[3*RW +: RW] = '0;
      exp_reg[3] = 32'hF;
      chk("w1c_hwset", reg_q[3*RW +: RW], exp_reg[3]);

      access("w1c_race", 32'hC, 1'b1, 32'h3, 4'b1111, 32'h1, 32'hF, 1'b0, 8'h08);
      exp_reg[3] = 32'hD;
      check_regs("w1c_race");

      access("oor_rd", 32'h20, 1'b0, 32'h0, 4'b0000, '0, 32'h0, 1'b1, 8'h00);
      access("oor_wr", 32'h24, 1'b1, 32'hFFFF_FFFF, 4'b1111, '0, 32'h0, 1'b1, 8'h00);
      check_regs("oor");

      access("ro_wr", 32'h10, 1'b1, 32'h1234, 4'b1111, '0, 32'h55, RO_ERR, 8'h00);
      check_regs("ro_wr");

      hw_we    = 8'b0111_1000;
      hw_wdata[3*RW +: RW] = 32'hFFFF_FFFF;
      hw_wdata[4*RW +: RW] = 32'h66;
      hw_wdata[5*RW +: RW] = 32'h100;
      hw_wdata[6*RW +: RW] = 32'hCAFE;
      hw_set[1*RW +: RW]   = 32'hFFFF;
      @(negedge clk);
      hw_we    = '0;
      hw_wdata = '0;
      hw_set   = '0;
      exp_reg[4] = 32'h66;
      exp_reg[5] = 32'h100;
      exp_reg[6] = 32'hCAFE;
      check_regs("hw_load");

      access("w1s_wr", 32'h14, 1'b1, 32'h11, 4'b0001, '0, 32'h100, 1'b0, 8'h20);
      exp_reg[5] = 32'h111;
      access("rw_hibyte", 32'h0, 1'b1, 32'hAABB_CCDD, 4'b1000, '0, 32'h0, 1'b0, 8'h01);
      exp_reg[0] = 32'hAA00_0000;
      check_regs("w1s_hibyte");

      exp_q.push_back('{rdata: 32'h0, err: 1'b0});
      bus.reg_addr  = 32'h1C;
      bus.reg_write = 1'b1;
      bus.reg_wdata = 32'h77;
      bus.reg_wstrb = 4'b1111;
      bus.reg_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_resp_ready", bus.reg_ready, 1'b0);
      chk("rst_resp_evt", wr_evt, '0);
      exp_reg = init_arr;
      check_regs("rst_resp");
      rst           = 1'b0;
      bus.reg_valid = 1'b0;

      rst           = 1'b1;
      bus.reg_wdata = 32'h99;
      bus.reg_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_commit_ready", bus.reg_ready, 1'b0);
      chk("rst_commit_reg7", reg_q[7*RW +: RW], 32'h0);
      rst           = 1'b0;
      bus.reg_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_commit_no_resp", bus.reg_ready, 1'b0);

      chk("pending_resp", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
